// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM encoding, IF/ID handoff record, reset vector.
package rv32i_types;

  localparam logic [31:0] IF_RESET_PC = 32'h4000_0060;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and ID; entry 0 is always the head.
module fetch_fifo
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  output logic [1:0]  occ,
  output if_id_t      head
);

  logic [31:0] pc0, pc1, instr0, instr1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ    <= '0;
      pc0    <= '0;
      pc1    <= '0;
      instr0 <= '0;
      instr1 <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          pc0    <= pc1;
          instr0 <= instr1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: new entry lands behind whatever remains after the pop.
          if (occ == 2'd1) begin
            pc0    <= push_pc;
            instr0 <= push_instr;
          end else begin
            pc0    <= pc1;
            instr0 <= instr1;
            pc1    <= push_pc;
            instr1 <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    head.valid = (occ != 2'd0);
    head.pc    = head.valid ? pc0 : '0;
    head.instr = head.valid ? instr0 : '0;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, redirect flush with in-flight discard,
// and a two-entry buffer toward ID.
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  fetch_state_t state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic [31:0]  req_addr, req_addr_n;
  logic [1:0]   occ, occ_next;
  logic         fill, pop, issue, can_issue;
  if_id_t       head;

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fill),
    .pop        (pop),
    .flush      (redirect_i),
    .push_pc    (req_addr),
    .push_instr (imem_rdata),
    .occ        (occ),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    issue      = 1'b0;
    pop        = head.valid && !stall_i && !redirect_i;
    fill       = (state == REQ) && imem_resp && !redirect_i;
    // Issue only when a response landing next could not overflow the buffer.
    occ_next   = occ + {1'b0, fill} - {1'b0, pop};
    can_issue  = (occ_next <= 2'd1);

    if (redirect_i) begin
      fetch_pc_n = redirect_pc_i;
      if (state != IDLE) state_n = imem_resp ? IDLE : DISCARD;
    end else begin
      case (state)
        IDLE:    issue = can_issue;
        REQ: begin
          if (imem_resp) begin
            if (can_issue) issue = 1'b1;
            else           state_n = IDLE;
          end
        end
        DISCARD: if (imem_resp) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

    if (issue) begin
      req_addr_n = fetch_pc;
      fetch_pc_n = fetch_pc + 32'd4;
      state_n    = REQ;
    end
  end

  assign imem_read    = (state == REQ) || (state == DISCARD);
  assign imem_address = req_addr;
  assign if_valid_o   = head.valid;
  assign if_pc_o      = head.pc;
  assign if_instr_o   = head.instr;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter: RESET_PC, 32'h4000_0060, first fetch address after reset.
REQ-002 The block SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 The block SHALL have port: rst  in  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port: imem_read  out  1  instruction-memory request, held until imem_resp.
REQ-005 The block SHALL have port: imem_address  out  32  request address, word-aligned, stable while imem_read=1.
REQ-006 The block SHALL have port: imem_rdata  in  32  instruction word, valid when imem_resp=1.
REQ-007 The block SHALL have port: imem_resp  in  1  single-cycle response strobe for the outstanding request.
REQ-008 The block SHALL have port: redirect_i  in  1  taken branch/jump from EX, flush and refetch.
REQ-009 The block SHALL have port: redirect_pc_i  in  32  target address of redirect.
REQ-010 The block SHALL have port: stall_i  in  1  ID cannot accept the head instruction this cycle.
REQ-011 The block SHALL have port: if_valid_o  out  1  head entry valid for ID.
REQ-012 The block SHALL have port: if_pc_o  out  32  PC of head entry (feeds ID pc_i).
REQ-013 The block SHALL have port: if_instr_o  out  32  instruction of head entry (feeds ID instr_i).

Function
REQ-014 Registers SHALL be: fetch_pc (next address to request), req_addr (address of outstanding request), state {IDLE, REQ, DISCARD}, 2-entry FIFO of {pc, instr} with occupancy occ 0..2.
REQ-015 imem_read SHALL be 1 exactly in REQ and DISCARD; imem_address SHALL equal req_addr.
REQ-016 Pop SHALL occur when if_valid_o=1 and stall_i=0; if_valid_o SHALL equal (occ!=0); if_pc_o/if_instr_o SHALL show the head entry, 0 when empty.
REQ-017 Issue condition: occ_next <= 1, where occ_next = end-of-cycle occupancy after this cycle's fill and pop; this guarantees space for every response.
REQ-018 Issue SHALL set req_addr <= fetch_pc, fetch_pc <= fetch_pc + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), state <= REQ.
REQ-019 IDLE: issue if condition holds, else stay IDLE.
REQ-020 REQ, imem_resp=1, no redirect: push {req_addr, imem_rdata}; issue again in the same cycle if condition holds (back-to-back), else go IDLE.
REQ-021 REQ, imem_resp=0: stay REQ, req_addr unchanged.
REQ-022 Push and pop in the same cycle SHALL leave occ unchanged; pop with occ=0 and push with occ=2 SHALL never occur.
REQ-023 Redirect SHALL have priority over fill, pop and issue: occ <= 0, fetch_pc <= redirect_pc_i.
REQ-024 Redirect in REQ without imem_resp SHALL go to DISCARD.
REQ-025 Redirect coinciding with imem_resp SHALL drop the response and go to IDLE.
REQ-026 Redirect in IDLE SHALL go to IDLE.
REQ-027 DISCARD SHALL hold imem_read with the old req_addr until imem_resp, drop that data, then go to IDLE.
REQ-028 Redirect in DISCARD SHALL update fetch_pc only and stay in DISCARD.
REQ-029 Stale instructions SHALL never appear on if_valid_o after the cycle in which redirect_i=1.
REQ-030 Latency SHALL be: issue cycle t, response cycle t+k (k>=1), if_valid_o=1 in cycle t+k+1.

Reset
REQ-031 On rst=0 the block SHALL asynchronously set: state=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, occ=0, FIFO contents 0.
REQ-032 On rst=0 the block SHALL asynchronously set outputs: imem_read=0, if_valid_o=0, if_pc_o=0, if_instr_o=0.
REQ-033 Reset mid-request SHALL abandon the outstanding request without waiting for imem_resp.
REQ-034 After release, the first imem_read=1 SHALL occur one cycle later with address RESET_PC.

Structure
REQ-035 The fetch state enum and the if_id_t struct {valid, pc, instr} SHALL be defined in the shared rv32i_types package.
REQ-036 RESET_PC default SHALL be a package constant.
REQ-037 The 2-entry FIFO SHALL be a sub-module fetch_fifo with push, pop, flush, occ and head outputs.

Verification
REQ-038 Reset release, memory k=1, stall_i=0 -> addresses 40000060, 64, 68, ... each held one cycle; if_valid_o continuous from cycle 3, PCs in order.
REQ-039 stall_i=1 for 5 cycles mid-stream -> occ reaches 2, imem_read stops, head PC constant; on release, no instruction lost or duplicated.
REQ-040 Redirect to 40000100 while request to 40000070 is outstanding (k=3) -> DISCARD, 40000070 data dropped, next request 40000100, if_pc_o=40000100.
REQ-041 Redirect to 40000200 in the same cycle as imem_resp -> response dropped, FIFO empty next cycle, next address 40000200.
REQ-042 Redirect_pc 0xFFFFFFFC with no stall -> requests FFFFFFFC then 00000000.
REQ-043 rst=0 asserted while imem_read=1 -> imem_read=0 in the same cycle; after release, fetch restarts at RESET_PC.
